// File: rtl/core_next_pc_pkg.sv
// Shared types for the fetch-PC selection unit: BTB entry layout and the 2-bit direction counter step.
package core_next_pc_pkg;

  localparam int MAX_XLEN = 64;

  // Tag and target are held at full width; core_btb zero-extends its narrower tag into the field.
  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/core_btb.sv
// Direct-mapped branch target buffer: combinational lookup on registered state, one EX-side update per cycle.
module core_btb
  import core_next_pc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic [XLEN-1:0] lookup_pc4,
  output logic            taken,
  output logic [XLEN-1:0] target,
  input  logic            update,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  btb_entry_t       entries_q [ENTRIES];
  btb_entry_t       rd_e;
  btb_entry_t       wr_e;
  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             wr_hit;

  assign rd_idx = IDX'(lookup_pc >> 2);
  assign rd_tag = TAG_W'(lookup_pc >> (IDX + 2));
  assign wr_idx = IDX'(update_pc >> 2);
  assign wr_tag = TAG_W'(update_pc >> (IDX + 2));

  assign rd_e   = entries_q[rd_idx];
  assign wr_e   = entries_q[wr_idx];
  assign rd_hit = rd_e.valid && (rd_e.tag == MAX_XLEN'(rd_tag));
  assign wr_hit = wr_e.valid && (wr_e.tag == MAX_XLEN'(wr_tag));

  assign taken  = rd_hit && rd_e.ctr[1];
  assign target = rd_hit ? rd_e.target[XLEN-1:0] : lookup_pc4;

  // A not-taken miss leaves the table alone so it never evicts a useful entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (update) begin
      if (wr_hit) begin
        entries_q[wr_idx].ctr <= ctr_step(wr_e.ctr, update_taken);
        if (update_taken) entries_q[wr_idx].target <= MAX_XLEN'(update_target);
      end else if (update_taken) begin
        entries_q[wr_idx] <= '{valid: 1'b1, tag: MAX_XLEN'(wr_tag),
                               target: MAX_XLEN'(update_target), ctr: 2'b10};
      end
    end
  end

endmodule

// File: rtl/core_next_pc.sv
// Next fetch-PC selection: prioritised redirect mux over BTB prediction and PC+4, plus handler vector
// and branch/mispredict accounting. Next-PC path is combinational; state updates on posedge clk.
module core_next_pc
  import core_next_pc_pkg::*;
#(
  parameter int              XLEN           = 64,
  parameter int              BTB_ENTRIES    = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
  parameter logic [XLEN-1:0] HANDLER_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_pc4,
  input  logic            taken_handler,
  input  logic            id_eret,
  input  logic [XLEN-1:0] epc,
  input  logic            id_jump,
  input  logic [XLEN-1:0] id_jump_addr,
  input  logic            id_jr,
  input  logic [XLEN-1:0] id_jr_data,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            vec_we,
  input  logic [XLEN-1:0] vec_wdata,
  output logic [XLEN-1:0] next_fetch_pc,
  output logic            flush,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  logic            btb_taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect;
  logic [XLEN-1:0] vec_q;

  core_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (fetch_pc),
    .lookup_pc4    (fetch_pc4),
    .taken         (btb_taken),
    .target        (pred_target),
    .update        (ex_branch && !reset),
    .update_pc     (ex_pc),
    .update_taken  (ex_taken),
    .update_target (ex_target)
  );

  assign pred_taken = btb_taken && !reset;
  assign mispredict = ex_branch &&
                      ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  assign redirect   = ex_taken ? ex_target : ex_pc + XLEN'(4);

  always_comb begin
    next_fetch_pc = fetch_pc4;
    flush         = 1'b1;
    if (reset)              next_fetch_pc = RESET_VECTOR;
    else if (taken_handler) next_fetch_pc = vec_q;
    else if (mispredict)    next_fetch_pc = redirect;
    else if (id_eret)       next_fetch_pc = epc;
    else if (id_jump)       next_fetch_pc = id_jump_addr;
    else if (id_jr)         next_fetch_pc = id_jr_data;
    else begin
      flush         = 1'b0;
      next_fetch_pc = pred_taken ? pred_target : fetch_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q            <= HANDLER_VECTOR;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (vec_we) vec_q <= vec_wdata;
      if (ex_branch) begin
        branch_count <= branch_count + 32'd1;
        if (mispredict) mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule
